// File: rtl/samplerz_rnd_buffer.sv
// Byte-granular randomness FIFO between the PRNG word stream and samplerz.
// Accepts 64-bit words and serves in-order requests of 1..9 bytes.
module samplerz_rnd_buffer #(
  parameter int unsigned DEPTH_BYTES = 32,
  parameter int unsigned LVL_W       = $clog2(DEPTH_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  output logic             in_ready,
  input  logic             req,
  input  logic [3:0]       req_bytes,
  output logic             ack,
  output logic [71:0]      rnd_data,
  output logic             req_err,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned PtrW = $clog2(DEPTH_BYTES);
  // One extra bit so ptr + 9 never overflows before the modulo fold.
  localparam int unsigned IdxW = PtrW + 1;
  localparam logic [IdxW-1:0]  DepthIdx = IdxW'(DEPTH_BYTES);
  localparam logic [LVL_W-1:0] DepthLvl = LVL_W'(DEPTH_BYTES);

  typedef enum logic [1:0] {StIdle, StAck, StErr} state_e;

  logic [7:0]       mem_q [DEPTH_BYTES];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  state_e           state_q, state_d;
  logic [71:0]      rnd_q, rnd_d;
  logic [71:0]      peek;
  logic             push, pop, req_legal;

  function automatic logic [PtrW-1:0] wrap_add(logic [PtrW-1:0] ptr, logic [3:0] n);
    logic [IdxW-1:0] sum;
    sum = IdxW'(ptr) + IdxW'(n);
    if (sum >= DepthIdx) sum = sum - DepthIdx;
    return sum[PtrW-1:0];
  endfunction

  assign in_ready  = ((DepthLvl - level_q) >= LVL_W'(8)) && !flush;
  assign push      = in_valid && in_ready;
  assign req_legal = (req_bytes != 4'd0) && (req_bytes <= 4'd9);
  // Pop uses the level from the start of the cycle; a same-cycle push is not visible.
  assign pop       = (state_q == StIdle) && req && req_legal && !flush &&
                     (level_q >= LVL_W'(req_bytes));

  always_comb begin
    peek = '0;
    for (int i = 0; i < 9; i++) begin
      if (4'(i) < req_bytes) begin
        peek[8*i +: 8] = mem_q[wrap_add(rd_ptr_q, 4'(i))];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + (push ? LVL_W'(8) : LVL_W'(0)) -
               (pop ? LVL_W'(req_bytes) : LVL_W'(0));
    if (push) wr_ptr_d = wrap_add(wr_ptr_q, 4'd8);
    if (pop)  rd_ptr_d = wrap_add(rd_ptr_q, req_bytes);

    if (flush) begin
      state_d  = StIdle;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req && !req_legal) begin
            state_d = StErr;
            rnd_d   = '0;
          end else if (pop) begin
            state_d = StAck;
            rnd_d   = peek;
          end
        end
        StAck, StErr: state_d = StIdle;
        default:      state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rnd_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Word writes are 8-aligned and depth is a multiple of 8, so a push never wraps mid-word.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[wr_ptr_q + PtrW'(i)] <= in_data[8*i +: 8];
      end
    end
  end

  assign ack      = (state_q != StIdle) && !flush;
  assign req_err  = (state_q == StErr) && !flush;
  assign rnd_data = rnd_q;
  assign level    = level_q;

endmodule
